// File: rtl/branch_redirect_ctrl_if.sv
// branch_redirect_ctrl_if: MEM-stage branch/hazard inputs and redirect/flush/stall outputs of the redirect controller
interface branch_redirect_ctrl_if;
  logic        branch;
  logic [8:0]  pc_mem_resolved;
  logic        mem_valid;
  logic        stall_req;
  logic        pc_load;
  logic [8:0]  pc_target;
  logic        flush_if;
  logic        flush_id;
  logic        flush_ex;
  logic        stall_if;
  logic        busy;
  logic [15:0] branch_count;
  modport master (output branch, pc_mem_resolved, mem_valid, stall_req,
                  input pc_load, pc_target, flush_if, flush_id, flush_ex, stall_if, busy, branch_count);
  modport slave (input branch, pc_mem_resolved, mem_valid, stall_req,
                 output pc_load, pc_target, flush_if, flush_id, flush_ex, stall_if, busy, branch_count);
endinterface

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: RUN/FLUSH/REFILL redirect FSM; optional saturating redirect counter under BRANCH_STATS_EN
module branch_redirect_ctrl #(
  parameter int REFILL_CYCLES = 3
) (
  input logic clk,
  input logic rst,
  branch_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, FLUSH, REFILL} state_t;
  localparam logic [2:0] LOAD = 3'(REFILL_CYCLES - 1);
  state_t r_state, w_next;
  logic [2:0] r_cnt, w_cnt_next;
  logic [8:0] r_pc_target;
  logic w_take, w_done, w_flush;
  assign w_take = (r_state == RUN) && bus.branch && bus.mem_valid;
  // FLUSH is the first busy cycle, so REFILL ends once the count would reach 0
  assign w_done = !bus.stall_req && (r_cnt <= 3'd1);
  always_comb begin
    w_next = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      RUN: w_next = w_take ? FLUSH : RUN;
      FLUSH: begin
        w_next = REFILL;
        w_cnt_next = LOAD;
      end
      REFILL: begin
        w_next = w_done ? RUN : REFILL;
        w_cnt_next = (bus.stall_req || r_cnt == 3'd0) ? r_cnt : r_cnt - 3'd1;
      end
      default: w_next = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt <= 3'd0;
      r_pc_target <= 9'd0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt_next;
      if (w_take) r_pc_target <= bus.pc_mem_resolved;
    end
  end
  assign w_flush = !rst && (r_state == FLUSH);
  assign bus.pc_load = w_flush;
  assign bus.flush_if = w_flush;
  assign bus.flush_id = w_flush;
  assign bus.flush_ex = w_flush;
  assign bus.stall_if = !rst && (r_state != FLUSH) && bus.stall_req;
  assign bus.busy = (r_state != RUN);
  assign bus.pc_target = r_pc_target;
`ifdef BRANCH_STATS_EN
  logic [15:0] r_branch_count;
  always_ff @(posedge clk) begin
    if (rst) r_branch_count <= 16'd0;
    else if (w_take && r_branch_count != 16'hFFFF) r_branch_count <= r_branch_count + 16'd1;
  end
  assign bus.branch_count = r_branch_count;
`else
  assign bus.branch_count = 16'd0;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed + random stimulus, transaction model and redirect-target scoreboard
module tb_branch_redirect_ctrl;
  localparam int R = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  logic [8:0] q[$];
  bit m_flush = 1'b0;
  int m_refill = 0;
  logic [8:0] m_target = 9'd0;
  logic [15:0] m_cnt = 16'd0;
  branch_redirect_ctrl_if bi();
  branch_redirect_ctrl #(.REFILL_CYCLES(R)) dut (.clk(clk), .rst(rst), .bus(bi));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  always @(negedge clk) if (chk_en) begin
    chk("busy", 16'(bi.busy), 16'(m_flush || m_refill > 0));
    chk("pc_load", 16'(bi.pc_load), 16'(m_flush && !rst));
    chk("flush", 16'({bi.flush_if, bi.flush_id, bi.flush_ex}), {13'd0, {3{m_flush && !rst}}});
    chk("stall_if", 16'(bi.stall_if), 16'(!rst && !m_flush && bi.stall_req));
    chk("pc_target", 16'(bi.pc_target), 16'(m_target));
`ifdef BRANCH_STATS_EN
    chk("branch_count", bi.branch_count, m_cnt);
`else
    chk("branch_count", bi.branch_count, 16'd0);
`endif
    if (bi.pc_load === 1'b1) begin
      if (q.size() > 0) chk("redirect_target", 16'(bi.pc_target), 16'(q.pop_front()));
      else chk("redirect_queue", 16'(q.size()), 16'd1);
    end
  end
  task automatic step(input logic r, input logic b, input logic v, input logic s, input logic [8:0] p);
    @(posedge clk);
    #1;
    rst = r;
    bi.branch = b;
    bi.mem_valid = v;
    bi.stall_req = s;
    bi.pc_mem_resolved = p;
    @(negedge clk);
    #1;
    if (r) begin
      if (m_flush && q.size() > 0) q.delete(0);
      m_flush = 1'b0;
      m_refill = 0;
      m_target = 9'd0;
      m_cnt = 16'd0;
    end else if (m_flush) begin
      m_flush = 1'b0;
      m_refill = (R > 1) ? R - 1 : 1;
    end else if (m_refill > 0) begin
      if (!s) m_refill--;
    end else if (b && v) begin
      m_flush = 1'b1;
      m_target = p;
      if (m_cnt != 16'hFFFF) m_cnt++;
      q.push_back(p);
    end
    chk_en = 1'b1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 9'd0);
  endtask
  initial begin
    bi.branch = 1'b0;
    bi.mem_valid = 1'b0;
    bi.stall_req = 1'b0;
    bi.pc_mem_resolved = 9'd0;
    step(1'b1, 1'b1, 1'b1, 1'b1, 9'h1FF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 9'h0A4);
    idle(4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 9'h0A4);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 9'd0);
    idle(4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 9'h0A4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 9'h010);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 9'h0B2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 9'd0);
    idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 9'h155);
    idle(4);
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'h077);
    step(1'b0, 1'b1, 1'b1, 1'b0, 9'h1FF);
    idle(4);
`ifdef BRANCH_STATS_EN
    force dut.r_branch_count = 16'hFFFE;
    #1;
    release dut.r_branch_count;
    m_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 9'(i * 7));
      idle(4);
    end
`endif
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, 9'($urandom));
    idle(8);
    chk("queue_drain", 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
